// File: rtl/rv_fetch.sv
// rv_fetch: instruction fetch stage.
// Owns the PC and issues word requests to instruction memory. Returned words are
// buffered together with their PC and handed to decode over a valid/ready pair.
// A redirect from EX restarts fetch at a new target and discards everything that
// belongs to the old stream.
//
// Ports
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   imem_req_o       request valid; imem_addr_o is the word-aligned byte address
//   imem_gnt_i       request accepted this cycle
//   imem_rvalid_i    response valid, in issue order; imem_rdata_i is the word
//   redirect_i       restart fetch at redirect_pc_i (low two bits forced to zero)
//   if_valid_o       instruction available; if_pc_o / if_instr_o describe it
//   if_ready_i       decode accepts the head entry
//
// State | meaning
// BOOT  | single idle cycle after reset release
// RUN   | normal fetch: issue by credit, push responses into the buffer
// DROP  | discard responses to requests issued before a redirect
module rv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o
);

    localparam int          PTR_W = $clog2(DEPTH);
    localparam int          CNT_W = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_DROP} state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   outst_q, outst_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0]   fl_wr_q, fl_wr_d, fl_rd_q, fl_rd_d;

    logic [31:0]        fl_pc_q     [DEPTH];
    logic [31:0]        buf_pc_q    [DEPTH];
    logic [31:0]        buf_instr_q [DEPTH];

    logic               credit_ok, issue, resp, push, pop;
    logic [1:0]         unused_pc_bits;

    assign unused_pc_bits = redirect_pc_i[1:0];

    // Buffered plus in-flight words never exceed DEPTH, so a response can always be pushed.
    assign credit_ok   = ({1'b0, outst_q} + {1'b0, count_q}) < (CNT_W + 1)'(DEPTH);
    assign imem_req_o  = (state_q == ST_RUN) && credit_ok && !redirect_i;
    assign imem_addr_o = pc_q;
    assign issue       = imem_req_o && imem_gnt_i;
    // With nothing outstanding any rvalid is a leftover from before reset.
    assign resp        = imem_rvalid_i && (outst_q != '0);
    assign push        = resp && (state_q == ST_RUN) && !redirect_i;

    assign if_valid_o  = (count_q != '0);
    assign pop         = if_valid_o && if_ready_i;
    assign if_pc_o     = if_valid_o ? buf_pc_q[head_q]    : pc_q;
    assign if_instr_o  = if_valid_o ? buf_instr_q[head_q] : NOP;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        outst_d = outst_q;
        drop_d  = drop_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        fl_wr_d = fl_wr_q;
        fl_rd_d = fl_rd_q;

        if (issue) begin
            pc_d    = pc_q + 32'd4;
            fl_wr_d = fl_wr_q + PTR_W'(1);
        end
        if (resp) begin
            fl_rd_d = fl_rd_q + PTR_W'(1);
        end
        case ({issue, resp})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase

        if (push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end

        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            ST_DROP: begin
                if (resp) begin
                    drop_d = drop_q - CNT_W'(1);
                end
                if (drop_d == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        // Everything still outstanding after this cycle belongs to the old stream.
        if (redirect_i) begin
            pc_d    = {redirect_pc_i[31:2], 2'b00};
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
            drop_d  = outst_d;
            state_d = ((state_q == ST_BOOT) || (outst_d == '0)) ? ST_RUN : ST_DROP;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            fl_wr_q <= '0;
            fl_rd_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            fl_wr_q <= fl_wr_d;
            fl_rd_q <= fl_rd_d;
        end
    end

    // Storage arrays need no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (issue) begin
            fl_pc_q[fl_wr_q] <= pc_q;
        end
        if (push) begin
            buf_pc_q[tail_q]    <= fl_pc_q[fl_rd_q];
            buf_instr_q[tail_q] <= imem_rdata_i;
        end
    end

endmodule

// File: tb/tb_rv_fetch.sv
module tb_rv_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b1;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        if_valid_o;
    logic        if_ready_i = 1'b1;
    logic [31:0] if_pc_o;
    logic [31:0] if_instr_o;

    logic        mem_hold = 1'b0;
    logic [31:0] mq [$];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ho_t;
    ho_t         hq [$];
    logic [31:0] iq [$];

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        gnt;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;
    vec_t vt [12];

    int n_vec = 0;
    int n_err = 0;

    rv_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .if_valid_o    (if_valid_o),
        .if_ready_i    (if_ready_i),
        .if_pc_o       (if_pc_o),
        .if_instr_o    (if_instr_o)
    );

    always #5 clk = ~clk;

    // In-order memory: a word granted in cycle N returns in N+1 unless held.
    // The returned word is the bitwise inverse of its address.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mq.delete();
            imem_rvalid_i <= 1'b0;
            imem_rdata_i  <= 32'h0;
        end else begin
            if (imem_req_o && imem_gnt_i) mq.push_back(imem_addr_o);
            if (!mem_hold && mq.size() != 0) begin
                imem_rvalid_i <= 1'b1;
                imem_rdata_i  <= ~mq.pop_front();
            end else begin
                imem_rvalid_i <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            if (if_valid_o && if_ready_i) hq.push_back('{pc: if_pc_o, instr: if_instr_o});
            if (imem_req_o && imem_gnt_i) iq.push_back(imem_addr_o);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        iq.delete();
        hq.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic wait_hq(input int n, input string nm);
        int k = 0;
        while (hq.size() < n && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(hq.size() >= n), 32'd1);
    endtask

    task automatic wait_iq(input int n, input string nm);
        int k = 0;
        while (iq.size() < n && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(iq.size() >= n), 32'd1);
    endtask

    task automatic chk_stream(input int n, input logic [31:0] base, input string nm);
        for (int i = 0; i < n && i < hq.size(); i++) begin
            chk({nm, "_pc"}, hq[i].pc, base + 32'(4 * i));
            chk({nm, "_instr"}, hq[i].instr, ~(base + 32'(4 * i)));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //          redir rpc           gnt rdy  req addr          vld pc
        vt[0]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
        vt[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vt[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vt[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 32'h00};
        vt[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
        vt[5]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0C, 1'b0, 32'h00};
        vt[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h08};
        vt[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
        vt[8]  = '{1'b1, 32'h83,       1'b1, 1'b1, 1'b0, 32'h14, 1'b0, 32'h00};
        vt[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'h00};
        vt[10] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h84, 1'b0, 32'h00};
        vt[11] = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h88, 1'b1, 32'h80};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_valid", 32'(if_valid_o), 32'd0);
        chk("rst_pc", if_pc_o, 32'h0);
        chk("rst_instr", if_instr_o, NOP);

        // Release and steady flow, including a redirect with a response in flight
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) next_cycle();
            redirect_i    = vt[i].redir;
            redirect_pc_i = vt[i].rpc;
            imem_gnt_i    = vt[i].gnt;
            if_ready_i    = vt[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), 32'(imem_req_o), 32'(vt[i].req));
            chk($sformatf("v%0d_addr", i), imem_addr_o, vt[i].addr);
            chk($sformatf("v%0d_valid", i), 32'(if_valid_o), 32'(vt[i].vld));
            if (vt[i].vld) begin
                chk($sformatf("v%0d_pc", i), if_pc_o, vt[i].pc);
                chk($sformatf("v%0d_instr", i), if_instr_o, ~vt[i].pc);
            end else begin
                chk($sformatf("v%0d_instr", i), if_instr_o, NOP);
            end
        end

        // Decode stall from reset: credit stops issue after DEPTH requests
        if_ready_i = 1'b0;
        redirect_i = 1'b0;
        do_reset();
        repeat (12) @(negedge clk);
        chk("stall_issues", 32'(iq.size()), 32'd2);
        chk("stall_req", 32'(imem_req_o), 32'd0);
        chk("stall_valid", 32'(if_valid_o), 32'd1);
        chk("stall_head", if_pc_o, 32'h0);
        next_cycle();
        if_ready_i = 1'b1;
        wait_hq(6, "stall_drain_timeout");
        chk_stream(6, 32'h0, "stall_drain");

        // Redirect with two stale requests outstanding
        mem_hold = 1'b1;
        do_reset();
        repeat (5) @(negedge clk);
        chk("drop_outstanding", 32'(iq.size()), 32'd2);
        chk("drop_req_full", 32'(imem_req_o), 32'd0);
        next_cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        mem_hold      = 1'b0;
        next_cycle();
        redirect_i = 1'b0;
        @(negedge clk);
        chk("drop_req", 32'(imem_req_o), 32'd0);
        chk("drop_addr", imem_addr_o, 32'h100);
        chk("drop_valid", 32'(if_valid_o), 32'd0);
        wait_hq(2, "drop_timeout");
        chk_stream(2, 32'h100, "drop");

        // Back-to-back redirects: only the second target reaches decode
        next_cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        next_cycle();
        redirect_pc_i = 32'h300;
        hq.delete();
        iq.delete();
        next_cycle();
        redirect_i = 1'b0;
        wait_hq(3, "b2b_timeout");
        chk_stream(3, 32'h300, "b2b");
        if (iq.size() > 0) chk("b2b_first_issue", iq[0], 32'h300);

        // Address wrap, then asynchronous reset mid-stream
        next_cycle();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        next_cycle();
        redirect_i = 1'b0;
        iq.delete();
        hq.delete();
        wait_iq(2, "wrap_issue_timeout");
        if (iq.size() >= 2) begin
            chk("wrap_issue0", iq[0], 32'hFFFF_FFFC);
            chk("wrap_issue1", iq[1], 32'h0000_0000);
        end
        wait_hq(2, "wrap_timeout");
        for (int i = 0; i < 2 && i < hq.size(); i++) begin
            chk("wrap_pc", hq[i].pc, 32'hFFFF_FFFC + 32'(4 * i));
            chk("wrap_instr", hq[i].instr, ~(32'hFFFF_FFFC + 32'(4 * i)));
        end
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid", 32'(if_valid_o), 32'd0);
        chk("arst_req", 32'(imem_req_o), 32'd0);
        chk("arst_instr", if_instr_o, NOP);
        chk("arst_addr", imem_addr_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
